// File: rtl/expr_eval_pkg.sv
// Shared definitions for the expression evaluator and its character recognizer:
// FSM state encodings and the ASCII constants of the expression alphabet.
package expr_eval_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    NUM  = 2'd1,
    OP   = 2'd2,
    FAIL = 2'd3
  } state_t;

  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;
  localparam logic [7:0] CH_ADD = 8'h2B;
  localparam logic [7:0] CH_MUL = 8'h2A;

endpackage

// File: rtl/expr_eval_char_class.sv
// Combinational ASCII classifier: flags digits and the two operators and
// extracts the numeric value of a digit (zero for anything else).
module char_class
  import expr_eval_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_digit,
  output logic       is_add,
  output logic       is_mul,
  output logic [3:0] dval
);

  logic [7:0] off_s;

  // Classify the character and derive the digit value
  always_comb begin
    off_s    = ch - CH_0;
    is_digit = (ch >= CH_0) && (ch <= CH_9);
    is_add   = (ch == CH_ADD);
    is_mul   = (ch == CH_MUL);
    if (is_digit) begin
      dval = off_s[3:0];
    end else begin
      dval = 4'd0;
    end
  end

endmodule

// File: rtl/expr_eval.sv
// Streaming evaluator for digit ('+'|'*' digit)* with '*' binding tighter
// than '+'; result/ok/err are registered and track every consumed character.
module expr_eval
  import expr_eval_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [7:0]   in,
  input  logic         in_valid,
  output logic [W-1:0] result,
  output logic         ok,
  output logic         err
);

  state_t         state_r, state_s;
  logic [W-1:0]   sum_r, sum_s;
  logic [W-1:0]   prod_r, prod_s;
  logic           pend_mul_r, pend_mul_s;
  logic [W-1:0]   result_s;
  logic           ok_s, err_s;
  logic           is_digit_s, is_add_s, is_mul_s;
  logic [3:0]     dval_s;
  logic [W-1:0]   dval_w_s;
  logic [W-1:0]   prod_new_s;
  logic           go_fail_s;

  char_class u_char_class (
    .ch       (in),
    .is_digit (is_digit_s),
    .is_add   (is_add_s),
    .is_mul   (is_mul_s),
    .dval     (dval_s)
  );

  // Next-state and datapath: sum holds completed terms, prod the open term
  always_comb begin
    state_s    = state_r;
    sum_s      = sum_r;
    prod_s     = prod_r;
    pend_mul_s = pend_mul_r;
    result_s   = result;
    ok_s       = ok;
    err_s      = err;
    go_fail_s  = 1'b0;
    dval_w_s   = {{(W-4){1'b0}}, dval_s};
    if (pend_mul_r) begin
      prod_new_s = prod_r * dval_w_s;
    end else begin
      prod_new_s = dval_w_s;
    end

    if (in_valid) begin
      case (state_r)
        INIT, OP: begin
          if (is_digit_s) begin
            state_s  = NUM;
            prod_s   = prod_new_s;
            result_s = sum_r + prod_new_s;
            ok_s     = 1'b1;
          end else begin
            go_fail_s = 1'b1;
          end
        end
        NUM: begin
          if (is_add_s) begin
            state_s    = OP;
            sum_s      = sum_r + prod_r;
            pend_mul_s = 1'b0;
            ok_s       = 1'b0;
          end else if (is_mul_s) begin
            state_s    = OP;
            pend_mul_s = 1'b1;
            ok_s       = 1'b0;
          end else begin
            go_fail_s = 1'b1;
          end
        end
        FAIL: begin
          state_s = FAIL;
        end
        default: begin
          go_fail_s = 1'b1;
        end
      endcase
    end else begin
      state_s = state_r;
    end

    // Entering FAIL pins the outputs until the next reset
    if (go_fail_s) begin
      state_s  = FAIL;
      result_s = '0;
      ok_s     = 1'b0;
      err_s    = 1'b1;
    end else begin
      err_s = err_s;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r    <= INIT;
      sum_r      <= '0;
      prod_r     <= '0;
      pend_mul_r <= 1'b0;
      result     <= '0;
      ok         <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_r    <= state_s;
      sum_r      <= sum_s;
      prod_r     <= prod_s;
      pend_mul_r <= pend_mul_s;
      result     <= result_s;
      ok         <= ok_s;
      err        <= err_s;
    end
  end

endmodule
